// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller.
// Holds the FSM state encoding, the hard-wired zero register index and a
// small helper that qualifies a source/destination register match.
package hazard_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // FSM states: RUN, BUBBLE, MEM_WAIT, ERR
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_BUBBLE   = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_ERR      = 2'd3;

    // A used source operand collides with a non-zero load destination.
    function automatic logic reg_hit(input logic [REG_W-1:0] src,
                                     input logic             used,
                                     input logic [REG_W-1:0] dst);
        return used && (src == dst) && (dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Memory-stall watchdog.
// Counts consecutive cycles with enable high and raises a sticky, registered
// expired flag on the edge where the count reaches MEM_TIMEOUT.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-low reset
//   enable  - stall cycle to be counted; low clears the count
//   expired - sticky timeout flag, cleared only by reset
module stall_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable,
    output logic expired
);

    localparam int unsigned WD_W = $clog2(MEM_TIMEOUT + 1);

    logic [WD_W-1:0] cnt_q, cnt_d;
    logic            expired_q, expired_d;

    // Count runs of enable; hold at MEM_TIMEOUT so it can never wrap.
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        if (!enable) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != WD_W'(MEM_TIMEOUT)) begin
                cnt_d = cnt_q + WD_W'(1);
            end
            if (cnt_q == WD_W'(MEM_TIMEOUT - 1)) begin
                expired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage pipeline hazard controller.
// Detects load-use hazards (one-cycle bubble), freezes the front end while
// data memory stalls, and watchdogs long memory stalls into a terminal error.
// Optional macro HAZARD_PERF_EN adds a saturating load-use stall counter.
// Ports:
//   clk_i, rst_i           - clock, synchronous active-low reset
//   ifid_rs_i/rt_i(_used)  - source registers of the ID instruction
//   idex_memread_i/rt_i    - load in EX and its destination
//   branch_taken_i         - branch resolved taken in ID
//   dmem_stall_i           - data memory not ready
//   hd_o                   - select zero-control bubble into ID/EX
//   pc_write_o             - PC write enable
//   ifid_write_o           - IF/ID write enable
//   ifid_flush_o           - zero IF/ID on the next edge
//   err_o                  - sticky memory-timeout error
//   stall_cnt_o            - load-use stall count (HAZARD_PERF_EN only)
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_rs_used_i,
    input  logic             ifid_rt_used_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             dmem_stall_i,
    output logic             hd_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             err_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o
`endif
);

    logic [1:0] state_q, state_d;
    logic       lu;
    logic       wd_enable;
    logic       wd_expired;

    assign lu = idex_memread_i &&
                (reg_hit(ifid_rs_i, ifid_rs_used_i, idex_rt_i) ||
                 reg_hit(ifid_rt_i, ifid_rt_used_i, idex_rt_i));

    // Every consecutive stall cycle counts, including the one that leaves RUN.
    assign wd_enable = dmem_stall_i && (state_q != ST_ERR);

    stall_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    assign err_o = wd_expired;

    // Next state and combinational pipeline controls.
    always_comb begin
        state_d      = state_q;
        hd_o         = 1'b0;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        if (!rst_i) begin
            // Bubble and flush so nothing issues while reset is held.
            hd_o         = 1'b1;
            ifid_flush_o = 1'b1;
            state_d      = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_BUBBLE: begin
                    if (dmem_stall_i) begin
                        state_d = ST_MEM_WAIT;
                    end else if (lu && (state_q == ST_RUN)) begin
                        // Stall wins over a taken branch: its operands are stale.
                        hd_o    = 1'b1;
                        state_d = ST_BUBBLE;
                    end else begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                        ifid_flush_o = branch_taken_i;
                        state_d      = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!dmem_stall_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
            if (wd_expired) begin
                state_d = ST_ERR;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_q, perf_d;

    // Saturating count of cycles that insert a bubble.
    always_comb begin
        perf_d = perf_q;
        if (hd_o && (perf_q != {CNT_W{1'b1}})) begin
            perf_d = perf_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign stall_cnt_o = perf_q;
`else
    logic [CNT_W-1:0] unused_perf;
    assign unused_perf = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int MEM_TO   = 64;
    localparam int CNT_W    = 3;
    localparam int PERF_MAX = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, xrt;
    logic       rsu, rtu, mr, br, st;
    logic       hd, pw, iw, fl, err;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MEM_TIMEOUT(MEM_TO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ifid_rs_i     (rs),
        .ifid_rt_i     (rt),
        .ifid_rs_used_i(rsu),
        .ifid_rt_used_i(rtu),
        .idex_memread_i(mr),
        .idex_rt_i     (xrt),
        .branch_taken_i(br),
        .dmem_stall_i  (st),
        .hd_o          (hd),
        .pc_write_o    (pw),
        .ifid_write_o  (iw),
        .ifid_flush_o  (fl),
        .err_o         (err)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt)
`endif
    );

`ifndef HAZARD_PERF_EN
    assign stall_cnt = '0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Outputs sampled mid-cycle by the most recent call of cycle().
    logic s_hd, s_pw, s_iw, s_fl, s_err;
    logic [CNT_W-1:0] s_cnt;

    // Reference model: pending-bubble flag, frozen-front-end flag, run length
    // of consecutive stall cycles, sticky error and bubble-cycle tally.
    bit m_valid = 0;
    bit m_err   = 0;
    bit m_wait  = 0;
    bit m_bub   = 0;
    int m_run   = 0;
    int m_perf  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, compare against the model, advance the model.
    task automatic cycle(input logic r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                         input logic a_rsu, input logic a_rtu, input logic a_mr,
                         input logic [4:0] a_xrt, input logic a_br, input logic a_st);
        bit lu_m, e_hd, e_pw, e_iw, e_fl;
        rst = r; rs = a_rs; rt = a_rt; rsu = a_rsu; rtu = a_rtu;
        mr = a_mr; xrt = a_xrt; br = a_br; st = a_st;
        @(negedge clk);
        s_hd = hd; s_pw = pw; s_iw = iw; s_fl = fl; s_err = err; s_cnt = stall_cnt;
        lu_m = a_mr && (a_xrt != 0) &&
               ((a_rsu && a_rs == a_xrt) || (a_rtu && a_rt == a_xrt));
        if (!r) begin
            e_hd = 1; e_pw = 0; e_iw = 0; e_fl = 1;
        end else if (a_st || m_wait || m_err) begin
            e_hd = 0; e_pw = 0; e_iw = 0; e_fl = 0;
        end else if (lu_m && !m_bub) begin
            e_hd = 1; e_pw = 0; e_iw = 0; e_fl = 0;
        end else begin
            e_hd = 0; e_pw = 1; e_iw = 1; e_fl = a_br;
        end
        chk("model_hd", 32'(s_hd), 32'(e_hd));
        chk("model_pc_write", 32'(s_pw), 32'(e_pw));
        chk("model_ifid_write", 32'(s_iw), 32'(e_iw));
        chk("model_flush", 32'(s_fl), 32'(e_fl));
        if (m_valid) begin
            chk("model_err", 32'(s_err), 32'(m_err));
`ifdef HAZARD_PERF_EN
            chk("model_stall_cnt", 32'(s_cnt), 32'(m_perf));
`endif
        end
        if (!r) begin
            m_valid = 1; m_err = 0; m_wait = 0; m_bub = 0; m_run = 0; m_perf = 0;
        end else begin
            if (e_hd && m_perf < PERF_MAX) m_perf++;
            m_run = a_st ? m_run + 1 : 0;
            if (m_run >= MEM_TO) m_err = 1;
            m_bub  = e_hd;
            m_wait = a_st;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic a_st);
        cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, a_st);
    endtask

    task automatic do_reset();
        cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic lu_cycle();
        cycle(1'b1, 5'd9, 5'd1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic       r;
        logic [4:0] rs, rt;
        logic       rsu, rtu, mr;
        logic [4:0] xrt;
        logic       br, st;
        logic       hd, pw, iw, fl;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                                input logic a_rsu, input logic a_rtu, input logic a_mr,
                                input logic [4:0] a_xrt, input logic a_br, input logic a_st,
                                input logic e_hd, input logic e_pw, input logic e_iw,
                                input logic e_fl);
        vec_t v;
        v.r = r; v.rs = a_rs; v.rt = a_rt; v.rsu = a_rsu; v.rtu = a_rtu; v.mr = a_mr;
        v.xrt = a_xrt; v.br = a_br; v.st = a_st;
        v.hd = e_hd; v.pw = e_pw; v.iw = e_iw; v.fl = e_fl;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int burst;
        logic r_rst, r_st;
        //           r  rs rt su tu mr xrt br st   hd pw iw fl
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1);  // reset held
        tbl[1]  = mk(1, 1, 2, 1, 1, 0, 0, 0, 0,   0, 1, 1, 0);  // plain issue
        tbl[2]  = mk(1, 5, 3, 1, 0, 1, 5, 0, 0,   1, 0, 0, 0);  // load-use on rs
        tbl[3]  = mk(1, 5, 3, 1, 0, 1, 5, 0, 0,   0, 1, 1, 0);  // no second bubble
        tbl[4]  = mk(1, 4, 0, 1, 1, 1, 0, 0, 0,   0, 1, 1, 0);  // r0 never hazards
        tbl[5]  = mk(1, 2, 7, 1, 0, 1, 7, 0, 0,   0, 1, 1, 0);  // rt not used
        tbl[6]  = mk(1, 2, 7, 1, 1, 1, 7, 1, 0,   1, 0, 0, 0);  // lu beats branch
        tbl[7]  = mk(1, 2, 7, 1, 1, 0, 7, 1, 0,   0, 1, 1, 1);  // branch after bubble
        tbl[8]  = mk(1, 1, 1, 1, 1, 0, 0, 1, 0,   0, 1, 1, 1);  // branch in RUN
        tbl[9]  = mk(1, 5, 3, 1, 0, 1, 5, 0, 1,   0, 0, 0, 0);  // stall beats lu
        tbl[10] = mk(1, 5, 3, 1, 0, 1, 5, 0, 0,   0, 0, 0, 0);  // stall drop, frozen
        tbl[11] = mk(1, 1, 2, 1, 1, 0, 0, 0, 0,   0, 1, 1, 0);  // back in RUN
        tbl[12] = mk(1, 6, 6, 0, 1, 1, 6, 0, 0,   1, 0, 0, 0);  // load-use on rt
        tbl[13] = mk(1, 6, 6, 0, 1, 1, 6, 0, 1,   0, 0, 0, 0);  // stall in BUBBLE
        tbl[14] = mk(1, 6, 6, 0, 1, 1, 6, 1, 0,   0, 0, 0, 0);  // drop cycle frozen
        tbl[15] = mk(1, 6, 6, 0, 1, 1, 6, 1, 0,   1, 0, 0, 0);  // lu re-evaluated
        tbl[16] = mk(1, 6, 6, 0, 1, 0, 6, 1, 0,   0, 1, 1, 1);  // branch after bubble

        rst = 0; rs = 0; rt = 0; rsu = 0; rtu = 0; mr = 0; xrt = 0; br = 0; st = 0;

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].r, tbl[i].rs, tbl[i].rt, tbl[i].rsu, tbl[i].rtu, tbl[i].mr,
                  tbl[i].xrt, tbl[i].br, tbl[i].st);
            chk($sformatf("vec%0d_hd", i), 32'(s_hd), 32'(tbl[i].hd));
            chk($sformatf("vec%0d_pc_write", i), 32'(s_pw), 32'(tbl[i].pw));
            chk($sformatf("vec%0d_ifid_write", i), 32'(s_iw), 32'(tbl[i].iw));
            chk($sformatf("vec%0d_flush", i), 32'(s_fl), 32'(tbl[i].fl));
            if (i > 0) chk($sformatf("vec%0d_err", i), 32'(s_err), 32'd0);
        end

        // Ten-cycle memory stall: frozen, no error, RUN after the drop.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            chk("stall10_pc_write", 32'(s_pw), 32'd0);
            chk("stall10_ifid_write", 32'(s_iw), 32'd0);
            chk("stall10_err", 32'(s_err), 32'd0);
        end
        idle(1'b0);
        chk("stall10_drop_frozen", 32'(s_pw), 32'd0);
        idle(1'b0);
        chk("stall10_run_again", 32'(s_pw), 32'd1);

        // Watchdog boundary: 63 stall cycles are tolerated, 64 are not.
        for (int i = 0; i < MEM_TO - 1; i++) idle(1'b1);
        idle(1'b0);
        chk("stall63_no_err", 32'(s_err), 32'd0);
        idle(1'b0);
        chk("stall63_run", 32'(s_pw), 32'd1);
        for (int i = 0; i < MEM_TO; i++) idle(1'b1);
        idle(1'b0);
        chk("stall64_err", 32'(s_err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            chk("err_sticky", 32'(s_err), 32'd1);
            chk("err_frozen", 32'(s_pw), 32'd0);
        end
        do_reset();
        chk("err_reset_hd", 32'(s_hd), 32'd1);
        idle(1'b0);
        chk("err_cleared", 32'(s_err), 32'd0);
        chk("err_reset_run", 32'(s_pw), 32'd1);

        // Reset in the middle of a stall clears state and the watchdog count.
        for (int i = 0; i < 5; i++) idle(1'b1);
        cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("midrst_hd", 32'(s_hd), 32'd1);
        chk("midrst_flush", 32'(s_fl), 32'd1);
        chk("midrst_pc_write", 32'(s_pw), 32'd0);
        chk("midrst_ifid_write", 32'(s_iw), 32'd0);
        idle(1'b0);
        chk("midrst_run", 32'(s_pw), 32'd1);
        for (int i = 0; i < MEM_TO - 1; i++) idle(1'b1);
        idle(1'b0);
        chk("midrst_wd_cleared", 32'(s_err), 32'd0);
        idle(1'b0);

`ifdef HAZARD_PERF_EN
        // Three separate load-use bubbles, then saturation at all-ones.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            lu_cycle();
            idle(1'b0);
        end
        idle(1'b0);
        chk("perf_three", 32'(s_cnt), 32'd3);
        for (int k = 0; k < 6; k++) begin
            lu_cycle();
            idle(1'b0);
        end
        idle(1'b0);
        chk("perf_saturate", 32'(s_cnt), 32'(PERF_MAX));
`endif

        // Randomised traffic with stall bursts, checked against the model.
        do_reset();
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = int'($urandom_range(1, 70));
            r_st = (burst > 0);
            if (burst > 0) burst--;
            r_rst = ($urandom_range(0, 199) != 0);
            cycle(r_rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), r_st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
